npu_mem_loader: RTL and testbench

- Parametrised host-to-NPU weight/image loader. It accepts a stream of 32-bit words from the Avalon-side register interface and demultiplexes them, in a fixed region order, into NUM_REGIONS on-chip RAM regions (default: image, conv, dense).
- Region lengths and lane packing are run-time configurable, so network size changes need no RTL edits.
- The block adds a valid/ready handshake, abort, zero-length region skipping, and a done pulse.

---
 rtl/npu_mem_pkg.sv | 21 ++
 rtl/npu_region_sel.sv | 29 ++
 rtl/npu_mem_loader.sv | 163 ++++++++++++++++
 tb/tb_npu_mem_loader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/npu_mem_pkg.sv
// Shared types and default sizing for the NPU memory loader.
//   loader_state_t : loader FSM encoding
//   REG_*          : default region indices (image, conv, dense)
//   *_WORDS        : default per-region word counts for the reference network
package npu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FINISH = 2'd2
  } loader_state_t;

  localparam int REG_IMAGE = 0;
  localparam int REG_CONV  = 1;
  localparam int REG_DENSE = 2;

  localparam int IMAGE_WORDS = 225;
  localparam int CONV_WORDS  = 18816;
  localparam int DENSE_WORDS = 4204;

endpackage

// File: rtl/npu_region_sel.sv
// Priority search: lowest region index >= from_i whose length is non-zero.
//   len_i   : per-region lengths, region r at [r*LEN_W +: LEN_W]
//   from_i  : first index to consider (may equal NUM_REGIONS -> nothing found)
//   found_o : a non-empty region exists at or after from_i
//   idx_o   : that region's index (0 when not found)
module npu_region_sel #(
  parameter int NUM_REGIONS = 3,
  parameter int LEN_W       = 16,
  parameter int IDX_W       = 2
) (
  input  logic [NUM_REGIONS*LEN_W-1:0] len_i,
  input  logic [IDX_W:0]               from_i,
  output logic                         found_o,
  output logic [IDX_W-1:0]             idx_o
);

  // Scan from the top down so the lowest qualifying index is written last.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
      if ((r >= int'(from_i)) && (len_i[r*LEN_W +: LEN_W] != '0)) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(r);
      end
    end
  end

endmodule

// File: rtl/npu_mem_loader.sv
// Host-to-NPU loader: demultiplexes a valid/ready word stream into
// NUM_REGIONS RAM regions, filled in index order with empty regions skipped.
//   clk, reset           : clock, synchronous active-high reset
//   start, abort         : begin a load (IDLE only) / drop an in-progress load
//   cfg_len, cfg_pack    : per-region word counts and lane-packing mode
//   wr_data/valid/ready  : input word stream
//   mem_we/addr/data     : registered RAM write port (1-cycle latency)
//   busy, done           : not IDLE / one-cycle completion pulse
//   cur_region           : region currently being filled
module npu_mem_loader
  import npu_mem_pkg::*;
#(
  parameter int NUM_REGIONS = 3,
  parameter int LANES       = 4,
  parameter int LANE_W      = 8,
  parameter int ADDR_W      = 15,
  localparam int DATA_W     = LANES * LANE_W,
  localparam int LEN_W      = ADDR_W + 1,
  localparam int IDX_W      = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  input  logic [NUM_REGIONS*LEN_W-1:0]  cfg_len,
  input  logic [NUM_REGIONS-1:0]        cfg_pack,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic [NUM_REGIONS*LANES-1:0]  mem_we,
  output logic [NUM_REGIONS*ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]             mem_data,
  output logic                          busy,
  output logic                          done,
  output logic [IDX_W-1:0]              cur_region
);

  loader_state_t                 state_q, state_d;
  logic [IDX_W-1:0]              cur_q, cur_d;
  logic [LEN_W-1:0]              cnt_q, cnt_d;
  logic [NUM_REGIONS*LEN_W-1:0]  len_q, len_d;
  logic [NUM_REGIONS-1:0]        pack_q, pack_d;
  logic [NUM_REGIONS*LANES-1:0]  we_q, we_d;
  logic [NUM_REGIONS*ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]             data_q, data_d;
  logic                          done_q, done_d;

  logic [NUM_REGIONS*LEN_W-1:0]  sel_len;
  logic [IDX_W:0]                sel_from;
  logic                          sel_found;
  logic [IDX_W-1:0]              sel_idx;
  logic [LEN_W-1:0]              cur_len;
  logic [DATA_W-1:0]             lane_word;
  logic                          accept;

  // One search instance serves both uses: from region 0 over the live config
  // at start, and from cur+1 over the shadow lengths at a region boundary.
  assign sel_len  = (state_q == IDLE) ? cfg_len : len_q;
  assign sel_from = (state_q == IDLE) ? '0 : ((IDX_W+1)'(cur_q) + 1'b1);

  npu_region_sel #(
    .NUM_REGIONS (NUM_REGIONS),
    .LEN_W       (LEN_W),
    .IDX_W       (IDX_W)
  ) u_sel (
    .len_i   (sel_len),
    .from_i  (sel_from),
    .found_o (sel_found),
    .idx_o   (sel_idx)
  );

  assign wr_ready = (state_q == LOAD) && !abort;
  assign accept   = wr_valid && wr_ready;
  assign cur_len  = len_q[cur_q*LEN_W +: LEN_W];

  // Lane 0 takes the most significant byte of the bus word.
  always_comb begin
    lane_word = '0;
    for (int l = 0; l < LANES; l++)
      lane_word[l*LANE_W +: LANE_W] = wr_data[(LANES-1-l)*LANE_W +: LANE_W];
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    pack_d  = pack_q;
    we_d    = '0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d  = cfg_len;
          pack_d = cfg_pack;
          cnt_d  = '0;
          if (sel_found) begin
            cur_d   = sel_idx;
            state_d = LOAD;
          end else begin
            state_d = FINISH;
          end
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (accept) begin
          we_d[cur_q*LANES +: LANES]    = pack_q[cur_q] ? {LANES{1'b1}} : LANES'(1);
          addr_d[cur_q*ADDR_W +: ADDR_W] = cnt_q[ADDR_W-1:0];
          data_d = pack_q[cur_q] ? lane_word : DATA_W'(wr_data[LANE_W-1:0]);
          if (cnt_q == cur_len - LEN_W'(1)) begin
            cnt_d = '0;
            if (sel_found) cur_d   = sel_idx;
            else           state_d = FINISH;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      FINISH: begin
        // done is registered, so it lands one cycle after the final write.
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cur_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      pack_q  <= '0;
      we_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      pack_q  <= pack_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_data   = data_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign cur_region = cur_q;

endmodule

// File: tb/tb_npu_mem_loader.sv
module tb_npu_mem_loader;

  logic        clk = 1'b0;
  logic        reset, start, abort, wr_valid, wr_ready, busy, done;
  logic [47:0] cfg_len;
  logic [2:0]  cfg_pack;
  logic [31:0] wr_data, mem_data;
  logic [11:0] mem_we;
  logic [44:0] mem_addr;
  logic [1:0]  cur_region;

  npu_mem_loader dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_len(cfg_len), .cfg_pack(cfg_pack), .wr_data(wr_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy), .done(done),
    .cur_region(cur_region)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int          cyc, start_cyc, done_cnt, done_cyc, last_we_cyc;
  int          addr_err, pat_err, data_err, sync_err, ready_seen, acc_cnt;
  int          reg1_seen, reg2_seen;
  int          wcount[3];
  int          exp_addr[3];
  logic [31:0] lastdata[3];
  logic [2:0]  pk;
  bit          acc_flag, busy_at_done;
  logic [31:0] q[$];

  task automatic clear_stats();
    done_cnt = 0; done_cyc = -1; last_we_cyc = -1;
    addr_err = 0; pat_err = 0; data_err = 0; sync_err = 0;
    ready_seen = 0; acc_cnt = 0; reg1_seen = 0; reg2_seen = 0;
    acc_flag = 0; busy_at_done = 1;
    for (int r = 0; r < 3; r++) begin
      wcount[r] = 0; exp_addr[r] = 0; lastdata[r] = '0;
    end
    q.delete();
  endtask

  // Advance to the next falling edge and collect what the DUT wrote.
  task automatic step();
    logic [3:0]  we4, pat;
    logic [31:0] w, expd;
    @(negedge clk);
    cyc++;
    for (int r = 0; r < 3; r++) begin
      we4 = mem_we[r*4 +: 4];
      if (we4 != 4'h0) begin
        pat = pk[r] ? 4'hF : 4'h1;
        if (we4 !== pat) pat_err++;
        if (mem_addr[r*15 +: 15] !== 15'(exp_addr[r])) addr_err++;
        exp_addr[r]++;
        wcount[r]++;
        last_we_cyc = cyc;
        lastdata[r] = mem_data;
        if (q.size() == 0) data_err++;
        else begin
          w = q.pop_front();
          expd = pk[r] ? {w[7:0], w[15:8], w[23:16], w[31:24]} : {24'h0, w[7:0]};
          if (mem_data !== expd) data_err++;
        end
      end
    end
    if ((mem_we != 12'h0) != acc_flag) sync_err++;
    acc_flag = 0;
    if (done) begin done_cnt++; done_cyc = cyc; busy_at_done = busy; end
    if (busy && cur_region == 2'd1) reg1_seen++;
    if (busy && cur_region == 2'd2) reg2_seen++;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic ab);
    wr_valid = v; wr_data = d; abort = ab;
    #1;
    if (wr_ready) ready_seen++;
    if (wr_valid && wr_ready) begin
      acc_flag = 1; acc_cnt++; q.push_back(wr_data);
    end
  endtask

  // Pulse start, then scribble on cfg to show it was latched.
  task automatic begin_load(input int l0, input int l1, input int l2, input logic [2:0] p);
    clear_stats();
    pk = p;
    cfg_len = {16'(l2), 16'(l1), 16'(l0)};
    cfg_pack = p;
    start = 1'b1;
    start_cyc = cyc;
    drive(1'b0, 32'h0, 1'b0);
    step();
    start = 1'b0;
    cfg_len = '0;
    cfg_pack = 3'b000;
  endtask

  // mode 0: continuous valid, 1: 1,0,1,1,0 pattern, 2: fixed 0xAABBCCDD
  task automatic feed(input int mode, input int budget);
    logic [4:0] patv = 5'b01101;
    logic v;
    int n = 0;
    for (int i = 0; i < budget && done_cnt == 0; i++) begin
      v = (mode == 1) ? patv[n % 5] : 1'b1;
      n++;
      drive(v, (mode == 2) ? 32'hAABBCCDD : $urandom, 1'b0);
      step();
    end
    drive(1'b0, 32'h0, 1'b0);
    step();
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
    step(); step();
    checks++; if (mem_we !== 12'h0) begin errors++; $display("FAIL reset_we: got %0h want 0", mem_we); end
    checks++; if (mem_addr !== 45'h0) begin errors++; $display("FAIL reset_addr: got %0h want 0", mem_addr); end
    checks++; if (mem_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %0h want 0", mem_data); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %0b%0b want 00", busy, done); end
    checks++; if (cur_region !== 2'd0) begin errors++; $display("FAIL reset_region: got %0d want 0", cur_region); end
    reset = 1'b0;
    step();
    drive(1'b1, 32'h12345678, 1'b0);
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL idle_ready: got %0b want 0", wr_ready); end
    step();
    drive(1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_default();
    begin_load(225, 18816, 4204, 3'b101);
    feed(0, 30000);
    checks++; if (acc_cnt !== 23245) begin errors++; $display("FAIL def_accepts: got %0d want 23245", acc_cnt); end
    checks++; if (wcount[0] !== 225) begin errors++; $display("FAIL def_image: got %0d want 225", wcount[0]); end
    checks++; if (wcount[1] !== 18816) begin errors++; $display("FAIL def_conv: got %0d want 18816", wcount[1]); end
    checks++; if (wcount[2] !== 4204) begin errors++; $display("FAIL def_dense: got %0d want 4204", wcount[2]); end
    checks++; if (addr_err !== 0 || pat_err !== 0) begin errors++; $display("FAIL def_addr_we: got addr_err=%0d we_err=%0d want 0", addr_err, pat_err); end
    checks++; if (data_err !== 0 || sync_err !== 0) begin errors++; $display("FAIL def_data_sync: got data_err=%0d sync_err=%0d want 0", data_err, sync_err); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL def_done_count: got %0d want 1", done_cnt); end
    checks++; if (done_cyc !== last_we_cyc + 1) begin errors++; $display("FAIL def_done_timing: got %0d want %0d", done_cyc, last_we_cyc + 1); end
    checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL def_busy_at_done: got %0b want 0", busy_at_done); end
  endtask

  task automatic test_lane_map();
    begin_load(1, 1, 0, 3'b001);
    feed(2, 20);
    checks++; if (lastdata[0] !== 32'hDDCCBBAA) begin errors++; $display("FAIL lane_packed: got %0h want ddccbbaa", lastdata[0]); end
    checks++; if (lastdata[1] !== 32'h000000DD) begin errors++; $display("FAIL lane_unpacked: got %0h want dd", lastdata[1]); end
    checks++; if (pat_err !== 0 || wcount[0] !== 1 || wcount[1] !== 1) begin errors++; $display("FAIL lane_we: got we_err=%0d n0=%0d n1=%0d want 0 1 1", pat_err, wcount[0], wcount[1]); end
  endtask

  task automatic test_zero_skip();
    begin_load(2, 0, 3, 3'b111);
    feed(0, 50);
    checks++; if (wcount[0] !== 2 || wcount[1] !== 0 || wcount[2] !== 3) begin errors++; $display("FAIL skip_counts: got %0d/%0d/%0d want 2/0/3", wcount[0], wcount[1], wcount[2]); end
    checks++; if (addr_err !== 0) begin errors++; $display("FAIL skip_addr: got %0d want 0", addr_err); end
    checks++; if (reg1_seen !== 0 || reg2_seen == 0) begin errors++; $display("FAIL skip_region: got r1=%0d r2=%0d want r1=0 r2>0", reg1_seen, reg2_seen); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL skip_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_all_zero();
    begin_load(0, 0, 0, 3'b111);
    feed(0, 10);
    checks++; if (wcount[0] + wcount[1] + wcount[2] !== 0) begin errors++; $display("FAIL zero_writes: got %0d want 0", wcount[0] + wcount[1] + wcount[2]); end
    checks++; if (ready_seen !== 0) begin errors++; $display("FAIL zero_ready: got %0d want 0", ready_seen); end
    checks++; if (done_cnt !== 1 || done_cyc - start_cyc > 2) begin errors++; $display("FAIL zero_done: got count=%0d delay=%0d want 1 <=2", done_cnt, done_cyc - start_cyc); end
  endtask

  task automatic test_backpressure();
    begin_load(2, 2, 1, 3'b010);
    feed(1, 50);
    checks++; if (acc_cnt !== 5) begin errors++; $display("FAIL bp_accepts: got %0d want 5", acc_cnt); end
    checks++; if (wcount[0] !== 2 || wcount[1] !== 2 || wcount[2] !== 1) begin errors++; $display("FAIL bp_counts: got %0d/%0d/%0d want 2/2/1", wcount[0], wcount[1], wcount[2]); end
    checks++; if (addr_err !== 0 || data_err !== 0 || sync_err !== 0) begin errors++; $display("FAIL bp_integrity: got addr=%0d data=%0d sync=%0d want 0", addr_err, data_err, sync_err); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL bp_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_abort();
    begin_load(5, 20, 3, 3'b111);
    for (int i = 0; i < 100 && acc_cnt < 15; i++) begin
      drive(1'b1, $urandom, 1'b0);
      step();
    end
    drive(1'b1, 32'hCAFEF00D, 1'b1);
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %0b want 0", wr_ready); end
    step();
    drive(1'b0, 32'h0, 1'b0);
    step(); step();
    checks++; if (wcount[0] !== 5 || wcount[1] !== 10 || wcount[2] !== 0) begin errors++; $display("FAIL abort_counts: got %0d/%0d/%0d want 5/10/0", wcount[0], wcount[1], wcount[2]); end
    checks++; if (done_cnt !== 0 || busy !== 1'b0) begin errors++; $display("FAIL abort_state: got done=%0d busy=%0b want 0 0", done_cnt, busy); end
    begin_load(3, 0, 0, 3'b001);
    feed(0, 20);
    checks++; if (wcount[0] !== 3 || addr_err !== 0 || done_cnt !== 1) begin errors++; $display("FAIL abort_restart: got n=%0d addr_err=%0d done=%0d want 3 0 1", wcount[0], addr_err, done_cnt); end
  endtask

  task automatic test_reset_mid();
    begin_load(2, 2, 4, 3'b111);
    for (int i = 0; i < 100 && acc_cnt < 6; i++) begin
      drive(1'b1, $urandom, 1'b0);
      step();
    end
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
    step();
    checks++; if (mem_we !== 12'h0 || mem_addr !== 45'h0 || mem_data !== 32'h0) begin errors++; $display("FAIL rstmid_mem: got we=%0h addr=%0h data=%0h want 0", mem_we, mem_addr, mem_data); end
    checks++; if (busy !== 1'b0 || wr_ready !== 1'b0 || cur_region !== 2'd0) begin errors++; $display("FAIL rstmid_ctrl: got busy=%0b rdy=%0b reg=%0d want 0", busy, wr_ready, cur_region); end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, $urandom, 1'b0);
      step();
    end
    drive(1'b0, 32'h0, 1'b0);
    checks++; if (wcount[2] !== 2 || busy !== 1'b0 || done_cnt !== 0) begin errors++; $display("FAIL rstmid_after: got dense=%0d busy=%0b done=%0d want 2 0 0", wcount[2], busy, done_cnt); end
  endtask

  initial begin
    cyc = 0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; wr_valid = 1'b0;
    wr_data = '0; cfg_len = '0; cfg_pack = '0; pk = '0;
    clear_stats();
    test_reset();
    test_default();
    test_lane_map();
    test_zero_skip();
    test_all_zero();
    test_backpressure();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
